// File: rtl/cacheline_mem_arbiter_pkg.sv
// Shared types and burst geometry for the cacheline memory arbiter and the caches.
// The geometry constants are localparams here so that both caches and the arbiter agree on line layout.
package cacheline_mem_arbiter_pkg;

  localparam int BEAT_W      = 64;
  localparam int BURST_BEATS = 4;
  localparam int LINE_W      = BEAT_W * BURST_BEATS;
  localparam int CNT_W       = $clog2(BURST_BEATS);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_BURST,
    RESP
  } arb_state_t;

  typedef enum logic {
    ICACHE,
    DCACHE
  } arb_owner_t;

endpackage

// File: rtl/cacheline_mem_arbiter_line_burst_buffer.sv
// One cacheline register plus beat counter: whole-line load, per-beat fill, per-beat readout.
// The counter wraps to zero after the last beat; done flags the operation on that beat.
module line_burst_buffer
  import cacheline_mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load,
  input  logic [LINE_W-1:0] load_line,
  input  logic              beat_we,
  input  logic [BEAT_W-1:0] beat_in,
  input  logic              beat_adv,
  output logic [BEAT_W-1:0] beat_out,
  output logic [LINE_W-1:0] line,
  output logic              done
);

  logic [BURST_BEATS-1:0][BEAT_W-1:0] line_q;
  logic [CNT_W-1:0]                   cnt_q;
  logic                               last;

  assign last     = (cnt_q == CNT_W'(BURST_BEATS - 1));
  assign done     = last & (beat_we | beat_adv);
  assign beat_out = line_q[cnt_q];
  assign line     = line_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (load) begin
        line_q <= load_line;
      end else if (beat_we) begin
        line_q[cnt_q] <= beat_in;
      end
      if (start) begin
        cnt_q <= '0;
      end else if (beat_we | beat_adv) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cacheline_mem_arbiter.sv
// Shares one burst memory port between icache and dcache; one line transaction in flight at a time.
// CACHELINE_ARB_RR_EN selects round-robin arbitration on contention; otherwise dcache has fixed priority.
module cacheline_mem_arbiter
  import cacheline_mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [31:0]       d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  arb_state_t        state_q, state_n;
  arb_owner_t        owner_q, win;
  logic [31:0]       addr_q, win_addr;
  logic              d_req, grant;
  logic              buf_start, buf_load, beat_we, beat_adv, done;
  logic [BEAT_W-1:0] beat_out;
  logic [LINE_W-1:0] line;

  assign d_req = d_read | d_write;

`ifdef CACHELINE_ARB_RR_EN
  arb_owner_t last_grant_q;

  always_comb begin
    win = d_req ? DCACHE : ICACHE;
    if (i_read && d_req) begin
      win = (last_grant_q == ICACHE) ? DCACHE : ICACHE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= ICACHE;
    end else if (grant) begin
      last_grant_q <= win;
    end
  end
`else
  always_comb begin
    win = d_req ? DCACHE : ICACHE;
  end
`endif

  assign win_addr = (win == DCACHE) ? d_addr : i_addr;

  always_comb begin
    state_n   = state_q;
    grant     = 1'b0;
    buf_start = 1'b0;
    buf_load  = 1'b0;
    beat_we   = 1'b0;
    beat_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_read || d_req) begin
          grant     = 1'b1;
          buf_start = 1'b1;
          // A simultaneous d_read is ignored when d_write is set.
          if (win == DCACHE && d_write) begin
            buf_load = 1'b1;
            state_n  = WR_BURST;
          end else begin
            state_n  = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (bmem_ready) begin
          buf_start = 1'b1;
          state_n   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (bmem_rvalid && bmem_raddr == addr_q) begin
          beat_we = 1'b1;
          if (done) state_n = RESP;
        end
      end
      WR_BURST: begin
        if (bmem_ready) begin
          beat_adv = 1'b1;
          if (done) state_n = RESP;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= ICACHE;
      addr_q  <= '0;
    end else begin
      state_q <= state_n;
      if (grant) begin
        owner_q <= win;
        addr_q  <= win_addr;
      end
    end
  end

  line_burst_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .start     (buf_start),
    .load      (buf_load),
    .load_line (d_wdata),
    .beat_we   (beat_we),
    .beat_in   (bmem_rdata),
    .beat_adv  (beat_adv),
    .beat_out  (beat_out),
    .line      (line),
    .done      (done)
  );

  assign bmem_read  = (state_q == RD_REQ);
  assign bmem_write = (state_q == WR_BURST);
  assign bmem_addr  = (bmem_read || bmem_write) ? addr_q : '0;
  assign bmem_wdata = bmem_write ? beat_out : '0;
  assign i_resp     = (state_q == RESP) && (owner_q == ICACHE);
  assign d_resp     = (state_q == RESP) && (owner_q == DCACHE);
  assign i_rdata    = (owner_q == ICACHE) ? line : '0;
  assign d_rdata    = (owner_q == DCACHE) ? line : '0;

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Directed bench for cacheline_mem_arbiter: reads, priority/round-robin, stalled writeback, stray beats, mid-burst reset.
module tb_cacheline_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_addr, d_addr, bmem_addr, bmem_raddr;
  logic         i_read, i_resp, d_read, d_write, d_resp;
  logic [255:0] i_rdata, d_wdata, d_rdata;
  logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [63:0]  bmem_wdata, bmem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  cacheline_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the read command, then returns n_beats beats tagged with addr.
  // A mismatched-tag beat is injected before beat index stray_at when stray_at >= 0.
  task automatic serve_read(input logic [31:0] addr, input logic [63:0] b0, input logic [63:0] b1,
                            input logic [63:0] b2, input logic [63:0] b3,
                            input int stray_at, input int n_beats);
    int waited = 0;
    logic [63:0] bv [4];
    bv[0] = b0; bv[1] = b1; bv[2] = b2; bv[3] = b3;
    while (bmem_read !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check("rd_cmd_seen", 256'(bmem_read), 256'(1));
    check("rd_cmd_addr", 256'(bmem_addr), 256'(addr));
    tick();
    for (int i = 0; i < n_beats; i++) begin
      if (i == stray_at) begin
        bmem_rvalid = 1'b1;
        bmem_raddr  = 32'h0000_9000;
        bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
      end
      bmem_rvalid = 1'b1;
      bmem_raddr  = addr;
      bmem_rdata  = bv[i];
      tick();
    end
    bmem_rvalid = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
  endtask

  initial begin
    logic exp_d;
    logic [63:0] base;
    rst = 1'b0;
    i_addr = '0; i_read = 1'b0;
    d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_bmem_read", 256'(bmem_read), 256'(0));
    check("rst_bmem_write", 256'(bmem_write), 256'(0));
    check("rst_bmem_addr", 256'(bmem_addr), 256'(0));
    check("rst_i_resp", 256'(i_resp), 256'(0));
    check("rst_d_resp", 256'(d_resp), 256'(0));
    check("rst_i_rdata", i_rdata, 256'(0));
    rst = 1'b1;
    tick();

    // icache read, immediate ready, beats A..D
    i_addr = 32'h0000_1000; i_read = 1'b1;
    serve_read(32'h0000_1000, 64'hA0A0_A0A0_A0A0_A0A0, 64'hB1B1_B1B1_B1B1_B1B1,
               64'hC2C2_C2C2_C2C2_C2C2, 64'hD3D3_D3D3_D3D3_D3D3, -1, 4);
    check("t1_i_resp", 256'(i_resp), 256'(1));
    check("t1_d_resp", 256'(d_resp), 256'(0));
    check("t1_i_rdata", i_rdata, {64'hD3D3_D3D3_D3D3_D3D3, 64'hC2C2_C2C2_C2C2_C2C2,
                                  64'hB1B1_B1B1_B1B1_B1B1, 64'hA0A0_A0A0_A0A0_A0A0});
    i_read = 1'b0;
    tick();
    check("t1_i_resp_pulse", 256'(i_resp), 256'(0));
    check("t1_i_rdata_hold", i_rdata, {64'hD3D3_D3D3_D3D3_D3D3, 64'hC2C2_C2C2_C2C2_C2C2,
                                       64'hB1B1_B1B1_B1B1_B1B1, 64'hA0A0_A0A0_A0A0_A0A0});

    // Simultaneous d_read/i_read: dcache first, then icache
    d_addr = 32'h0000_2000; d_read = 1'b1;
    i_addr = 32'h0000_1000; i_read = 1'b1;
    serve_read(32'h0000_2000, 64'h11, 64'h22, 64'h33, 64'h44, -1, 4);
    check("t2_d_resp", 256'(d_resp), 256'(1));
    check("t2_i_resp_idle", 256'(i_resp), 256'(0));
    check("t2_d_rdata", d_rdata, {64'h44, 64'h33, 64'h22, 64'h11});
    d_read = 1'b0;
    tick();
    serve_read(32'h0000_1000, 64'h55, 64'h66, 64'h77, 64'h88, -1, 4);
    check("t2_i_resp", 256'(i_resp), 256'(1));
    check("t2_d_resp_idle", 256'(d_resp), 256'(0));
    check("t2_i_rdata", i_rdata, {64'h88, 64'h77, 64'h66, 64'h55});
    i_read = 1'b0;
    tick();

    // Both requesting continuously for three transactions
    d_addr = 32'h0000_2000; d_read = 1'b1;
    i_addr = 32'h0000_1000; i_read = 1'b1;
    for (int t = 0; t < 3; t++) begin
`ifdef CACHELINE_ARB_RR_EN
      exp_d = (t != 1);
`else
      exp_d = 1'b1;
`endif
      base = 64'h100 * 64'(t + 1);
      serve_read(exp_d ? 32'h0000_2000 : 32'h0000_1000, base, base + 64'd1, base + 64'd2,
                 base + 64'd3, -1, 4);
      check("t3_d_resp", 256'(d_resp), 256'(exp_d));
      check("t3_i_resp", 256'(i_resp), 256'(!exp_d));
      check("t3_rdata", exp_d ? d_rdata : i_rdata,
            {base + 64'd3, base + 64'd2, base + 64'd1, base});
      if (t == 2) begin
        d_read = 1'b0;
        i_read = 1'b0;
      end
      tick();
    end

    // dcache writeback with a 3-cycle stall on the second beat
    d_addr  = 32'h0000_3000; d_write = 1'b1;
    d_wdata = {64'h4444, 64'h3333, 64'h2222, 64'h1111};
    bmem_ready = 1'b1;
    tick();
    check("t4_wr_valid", 256'(bmem_write), 256'(1));
    check("t4_wr_addr", 256'(bmem_addr), 256'(32'h0000_3000));
    check("t4_beat0", 256'(bmem_wdata), 256'(64'h1111));
    tick();
    check("t4_beat1", 256'(bmem_wdata), 256'(64'h2222));
    bmem_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("t4_stall_valid", 256'(bmem_write), 256'(1));
      check("t4_stall_beat1", 256'(bmem_wdata), 256'(64'h2222));
    end
    bmem_ready = 1'b1;
    tick();
    check("t4_beat2", 256'(bmem_wdata), 256'(64'h3333));
    check("t4_d_resp_early", 256'(d_resp), 256'(0));
    tick();
    check("t4_beat3", 256'(bmem_wdata), 256'(64'h4444));
    tick();
    check("t4_d_resp", 256'(d_resp), 256'(1));
    check("t4_wr_done", 256'(bmem_write), 256'(0));
    check("t4_i_resp", 256'(i_resp), 256'(0));
    d_write = 1'b0;
    tick();

    // Stray returning beat with a foreign tag mid-burst
    i_addr = 32'h0000_5000; i_read = 1'b1;
    serve_read(32'h0000_5000, 64'hA1, 64'hB2, 64'hC3, 64'hD4, 2, 4);
    check("t5_i_resp", 256'(i_resp), 256'(1));
    check("t5_i_rdata", i_rdata, {64'hD4, 64'hC3, 64'hB2, 64'hA1});
    i_read = 1'b0;
    tick();

    // Reset mid-burst after two beats
    i_addr = 32'h0000_6000; i_read = 1'b1;
    serve_read(32'h0000_6000, 64'hE1, 64'hE2, 64'hE3, 64'hE4, -1, 2);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_bmem_read", 256'(bmem_read), 256'(0));
    check("t6_rst_bmem_addr", 256'(bmem_addr), 256'(0));
    check("t6_rst_i_rdata", i_rdata, 256'(0));
    check("t6_rst_i_resp", 256'(i_resp), 256'(0));
    i_read = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("t6_no_i_resp", 256'(i_resp), 256'(0));
    check("t6_no_d_resp", 256'(d_resp), 256'(0));
    d_addr = 32'h0000_7000; d_read = 1'b1;
    serve_read(32'h0000_7000, 64'hF1, 64'hF2, 64'hF3, 64'hF4, -1, 4);
    check("t6_d_resp", 256'(d_resp), 256'(1));
    check("t6_d_rdata", d_rdata, {64'hF4, 64'hF3, 64'hF2, 64'hF1});
    d_read = 1'b0;
    tick();
    check("t6_d_resp_pulse", 256'(d_resp), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cacheline_mem_arbiter.md
Name: cacheline_mem_arbiter

Overview:
Shares the single burst memory port between the instruction-cache miss path and the data-cache miss/writeback path.
- Each requester issues cacheline-granular reads or writes.
- The block arbitrates between them and serializes or deserializes each line into BURST_BEATS memory beats.
- It sits between both caches and the memory model/DRAM interface.
- Only one transaction is in flight at a time.

Parameters:
BEAT_W, 64, memory beat width in bits
BURST_BEATS, 4, beats per cacheline
LINE_W, BEAT_W*BURST_BEATS (256), cacheline width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
i_addr  in  32  icache line address (line-aligned)
i_read  in  1  icache read request, level-held until i_resp
i_rdata  out  LINE_W  line returned to icache
i_resp  out  1  one-cycle completion pulse to icache
d_addr  in  32  dcache line address
d_read  in  1  dcache read request, level-held
d_write  in  1  dcache writeback request, level-held
d_wdata  in  LINE_W  writeback line
d_rdata  out  LINE_W  line returned to dcache
d_resp  out  1  one-cycle completion pulse to dcache
bmem_addr  out  32  memory address
bmem_read  out  1  read command
bmem_write  out  1  write beat valid
bmem_wdata  out  BEAT_W  write beat
bmem_ready  in  1  memory accepts command/beat this cycle
bmem_raddr  in  32  address tag of returning beat
bmem_rdata  in  BEAT_W  returning beat
bmem_rvalid  in  1  returning beat valid

Behaviour:
- FSM states: IDLE, RD_REQ, RD_DATA, WR_BURST, RESP. Beat counter is clog2(BURST_BEATS) bits wide.
- Reset (rst low, asynchronous):
  - state=IDLE, counter=0, owner=ICACHE, last_grant=ICACHE.
  - All outputs 0; line buffer cleared.
  - Reset mid-burst abandons the transaction; no resp is issued.
- IDLE:
  - Samples requests; a winner is chosen only if any request is active.
  - Latches owner, address and (for writes) d_wdata.
  - Read goes to RD_REQ; d_write goes to WR_BURST.
  - d_read and d_write both high is illegal; write takes precedence.
- RD_REQ:
  - bmem_read=1, bmem_addr=latched address.
  - On bmem_ready, go to RD_DATA with counter=0.
- RD_DATA:
  - Each bmem_rvalid with bmem_raddr==latched address writes bmem_rdata into line slice [counter*BEAT_W +: BEAT_W], then counter++.
  - After beat BURST_BEATS-1, go to RESP.
  - Beats with a mismatched raddr, and rvalid in any other state, are ignored.
- WR_BURST:
  - bmem_write=1, bmem_addr=latched address, bmem_wdata=slice[counter].
  - Counter advances only on bmem_ready; stalled beats hold value.
  - On the last accepted beat, go to RESP.
- RESP:
  - Owner's resp=1 for exactly one cycle; owner's rdata=line buffer (held stable until the next grant).
  - Next state IDLE; requests are ignored in the RESP cycle.
  - Requesters deassert on the cycle after resp.
- Latency: read = 1 (IDLE) + RD_REQ cycles + 4 beats + 1 (RESP). Unstalled write = 1+4+1 = 6 cycles.
- Fixed priority (default): dcache beats icache when both request in the same IDLE cycle.
- Non-owner resp stays 0 throughout.

Optional Feature:
CACHELINE_ARB_RR_EN
- Defined: round-robin arbitration. On contention, the requester not equal to last_grant wins; last_grant updates on every grant.
- Undefined: fixed dcache priority; last_grant is unused and optimized away.

Decomposition:
- rv32i_types package gains:
  - arb_state_t enum {IDLE, RD_REQ, RD_DATA, WR_BURST, RESP}
  - arb_owner_t enum {ICACHE, DCACHE}
  - constants BURST_BEATS and BEAT_W, shared with the caches
- One sub-module, line_burst_buffer: LINE_W register plus beat counter.
  - Load-line, shift-in-beat and select-out-beat operations.
  - Done flag on the last beat.

Test Plan:
- icache read of 0x0000_1000, ready immediate, 4 rvalid beats A,B,C,D → i_rdata={D,C,B,A}, i_resp pulses once on the cycle after beat D; d_resp stays 0.
- d_read 0x2000 and i_read 0x1000 asserted in the same cycle (fixed priority) → 0x2000 served first; after d_resp, the icache is granted at the next IDLE.
- CACHELINE_ARB_RR_EN defined, both requesting continuously for 3 transactions → grant order D, I, D.
- d_write 0x3000, line 0x…4444_3333_2222_1111 split into beats 1111, 2222, 3333, 4444, bmem_ready low on beat 2 for 3 cycles → beat 2 held stable; all 4 beats emitted in order; d_resp after beat 4.
- Read with a stray rvalid (raddr=0x9000) mid-burst → the stray beat is ignored and the line is correct.
- rst asserted low during RD_DATA after 2 beats → outputs 0 immediately; no resp; the next request completes normally.
